// File: rtl/board_reset_ctrl_if.sv
// Reset-source and SoC-reset signal bundle for board_reset_ctrl.
// The master drives the pads and requests; the slave (the controller) drives the reset, causes and busy.
interface board_reset_ctrl_if #(
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC-1:0] src_i;
    logic [NUM_SRC-1:0] src_en_i;
    logic               sw_rst_req_i;
    logic               cause_clr_i;
    logic               rst_n_o;
    logic [NUM_SRC:0]   rst_cause_o;
    logic               busy_o;

    modport master (
        output src_i, src_en_i, sw_rst_req_i, cause_clr_i,
        input  rst_n_o, rst_cause_o, busy_o
    );

    modport slave (
        input  src_i, src_en_i, sw_rst_req_i, cause_clr_i,
        output rst_n_o, rst_cause_o, busy_o
    );
endinterface

// File: rtl/board_reset_ctrl.sv
// Board reset controller: synchronises, masks and debounces reset pads, then drives
// a stretched, registered active-low SoC reset and a sticky reset-cause register.
module board_reset_ctrl #(
    parameter int                 NUM_SRC         = 2,
    parameter logic [NUM_SRC-1:0] SRC_ACTIVE_LOW  = 2'b10,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 16,
    parameter int                 STRETCH_CYCLES  = 64
) (
    input logic               ref_clk_i,
    input logic               rst_i,
    board_reset_ctrl_if.slave bus
);
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SCNT_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCNT_W-1:0] ST_LAST = SCNT_W'(STRETCH_CYCLES - 1);

    typedef enum logic [1:0] {HOLD, STRETCH, RUN} state_e;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] act;
    logic [NUM_SRC-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]   cnt_q [NUM_SRC];
    logic [CNT_W-1:0]   cnt_d [NUM_SRC];
    state_e             state_q, state_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic               rst_n_q, busy_q;
    logic [NUM_SRC:0]   cause_q, cause_d;
    logic               any;

    // Sync flops reload the inactive pad level so a reset never fakes an assertion.
    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= SRC_ACTIVE_LOW;
        end else begin
            sync_q[0] <= bus.src_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign act = (sync_q[SYNC_STAGES-1] ^ SRC_ACTIVE_LOW) & bus.src_en_i;

    always_comb begin
        stable_d = stable_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            cnt_d[k] = '0;
            if (act[k] != stable_q[k]) begin
                if (cnt_q[k] == DB_LAST) stable_d[k] = ~stable_q[k];
                else                     cnt_d[k]    = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    assign any     = (|stable_q) | bus.sw_rst_req_i;
    assign cause_d = (bus.cause_clr_i ? '0 : cause_q) | {bus.sw_rst_req_i, stable_q};

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        case (state_q)
            RUN: begin
                if (any) state_d = HOLD;
            end
            HOLD: begin
                if (!any) begin
                    state_d = STRETCH;
                    scnt_d  = '0;
                end
            end
            STRETCH: begin
                if (any) begin
                    state_d = HOLD;
                    scnt_d  = '0;
                end else if (scnt_q == ST_LAST) begin
                    state_d = RUN;
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            stable_q <= '0;
            for (int k = 0; k < NUM_SRC; k++) cnt_q[k] <= '0;
            state_q  <= STRETCH;
            scnt_q   <= '0;
            rst_n_q  <= 1'b0;
            busy_q   <= 1'b1;
            cause_q  <= '0;
        end else begin
            stable_q <= stable_d;
            for (int k = 0; k < NUM_SRC; k++) cnt_q[k] <= cnt_d[k];
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            rst_n_q  <= (state_d == RUN);
            busy_q   <= (state_d != RUN);
            cause_q  <= cause_d;
        end
    end

    assign bus.rst_n_o     = rst_n_q;
    assign bus.busy_o      = busy_q;
    assign bus.rst_cause_o = cause_q;
endmodule

// File: tb/tb_board_reset_ctrl.sv
// Self-checking bench for board_reset_ctrl: directed latency/boundary scenarios
// plus a randomized run compared against a history-based reference model.
module tb_board_reset_ctrl;
    localparam int         NS = 2;
    localparam logic [1:0] AL = 2'b10;
    localparam int         SS = 2;
    localparam int         DB = 4;
    localparam int         ST = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    board_reset_ctrl_if #(.NUM_SRC(NS)) bus ();

    board_reset_ctrl #(
        .NUM_SRC(NS), .SRC_ACTIVE_LOW(AL), .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DB), .STRETCH_CYCLES(ST)
    ) dut (
        .ref_clk_i(clk),
        .rst_i    (rst),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: pad history feeds the synchroniser delay, a window of
    // normalised levels decides debounced flips, and the reset is released
    // once no cause has been seen for STRETCH+1 consecutive edges.
    logic [NS-1:0] pin_hist [$];
    logic [NS-1:0] act_win  [$];
    int            since    [NS];
    logic [NS-1:0] m_stable;
    int            m_quiet;
    logic          m_rstn;
    logic [NS:0]   m_cause;

    task automatic model_step(input logic r, input logic [NS-1:0] src, input logic [NS-1:0] en,
                              input logic sw, input logic clr);
        logic [NS-1:0] sync_out, a;
        logic          any, ok;
        if (r) begin
            pin_hist.delete();
            for (int i = 0; i < SS; i++) pin_hist.push_back(AL);
            act_win.delete();
            for (int k = 0; k < NS; k++) since[k] = 0;
            m_stable = '0;
            m_quiet  = 1;
            m_rstn   = 1'b0;
            m_cause  = '0;
        end else begin
            any     = (|m_stable) | sw;
            m_cause = (clr ? '0 : m_cause) | {sw, m_stable};
            if (any) m_quiet = 0;
            else if (m_quiet < 1000) m_quiet++;
            m_rstn   = (m_quiet >= ST + 1);
            sync_out = pin_hist.pop_front();
            pin_hist.push_back(src);
            a = (sync_out ^ AL) & en;
            act_win.push_back(a);
            if (act_win.size() > DB) void'(act_win.pop_front());
            for (int k = 0; k < NS; k++) begin
                since[k]++;
                ok = (since[k] >= DB);
                if (ok)
                    for (int i = 0; i < DB; i++)
                        if (act_win[act_win.size() - 1 - i][k] == m_stable[k]) ok = 1'b0;
                if (ok) begin
                    m_stable[k] = ~m_stable[k];
                    since[k]    = 0;
                end
            end
        end
    endtask

    task automatic tick();
        logic [NS-1:0] s, e;
        logic          sw, clr, r;
        s = bus.src_i; e = bus.src_en_i; sw = bus.sw_rst_req_i; clr = bus.cause_clr_i; r = rst;
        @(posedge clk);
        model_step(r, s, e, sw, clr);
        #1;
    endtask

    task automatic test_reset();
        int bad, n;
        rst = 1'b1;
        bus.src_i = 2'b10; bus.src_en_i = 2'b11; bus.sw_rst_req_i = 1'b0; bus.cause_clr_i = 1'b0;
        bad = 0;
        repeat (3) begin
            tick();
            if (bus.rst_n_o !== 1'b0 || bus.busy_o !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_hold: rst_n=%b busy=%b required rst_n=0 busy=1", bus.rst_n_o, bus.busy_o);
        end
        tests++;
        if (bus.rst_cause_o !== 3'b000) begin
            fails++;
            $display("FAIL reset_cause: got %b required 000", bus.rst_cause_o);
        end
        rst = 1'b0;
        n = 0;
        while (bus.rst_n_o !== 1'b1 && n < 50) begin tick(); n++; end
        tests++;
        if (n != ST) begin
            fails++;
            $display("FAIL reset_release: rst_n rose after %0d cycles, required %0d", n, ST);
        end
        tests++;
        if (bus.busy_o !== 1'b0 || bus.rst_cause_o !== 3'b000) begin
            fails++;
            $display("FAIL reset_run: busy=%b cause=%b required busy=0 cause=000", bus.busy_o, bus.rst_cause_o);
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        bus.src_i[0] = 1'b1;
        repeat (3) tick();
        bus.src_i[0] = 1'b0;
        repeat (20) begin
            tick();
            if (bus.rst_n_o !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL glitch_filter: rst_n low for %0d cycles, required 0", bad);
        end
        tests++;
        if (bus.rst_cause_o !== 3'b000) begin
            fails++;
            $display("FAIL glitch_cause: got %b required 000", bus.rst_cause_o);
        end
    endtask

    task automatic test_button();
        int n, m;
        bus.src_i[0] = 1'b1;
        n = 0;
        while (bus.rst_n_o !== 1'b0 && n < 40) begin tick(); n++; end
        tests++;
        if (n != SS + DB + 1) begin
            fails++;
            $display("FAIL button_assert: rst_n fell after %0d cycles, required %0d", n, SS + DB + 1);
        end
        repeat (20 - n) tick();
        bus.src_i[0] = 1'b0;
        m = 0;
        while (bus.rst_n_o !== 1'b1 && m < 60) begin tick(); m++; end
        tests++;
        if (m != SS + DB + ST + 1) begin
            fails++;
            $display("FAIL button_release: rst_n rose %0d cycles after release, required %0d", m, SS + DB + ST + 1);
        end
        tests++;
        if (bus.rst_cause_o !== 3'b001) begin
            fails++;
            $display("FAIL button_cause: got %b required 001", bus.rst_cause_o);
        end
        bus.cause_clr_i = 1'b1;
        tick();
        bus.cause_clr_i = 1'b0;
        tests++;
        if (bus.rst_cause_o !== 3'b000) begin
            fails++;
            $display("FAIL button_clear: got %b required 000", bus.rst_cause_o);
        end
    endtask

    task automatic test_sw_reset();
        int m;
        bus.sw_rst_req_i = 1'b1;
        tick();
        bus.sw_rst_req_i = 1'b0;
        tests++;
        if (bus.rst_n_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.rst_cause_o !== 3'b100) begin
            fails++;
            $display("FAIL sw_assert: rst_n=%b busy=%b cause=%b required 0 1 100",
                     bus.rst_n_o, bus.busy_o, bus.rst_cause_o);
        end
        m = 0;
        while (bus.rst_n_o !== 1'b1 && m < 40) begin tick(); m++; end
        tests++;
        if (m != ST + 1) begin
            fails++;
            $display("FAIL sw_low_time: rst_n low %0d cycles, required %0d", m, ST + 1);
        end
        bus.cause_clr_i = 1'b1;
        tick();
        bus.cause_clr_i = 1'b0;
        tests++;
        if (bus.rst_cause_o !== 3'b000) begin
            fails++;
            $display("FAIL sw_clear: got %b required 000", bus.rst_cause_o);
        end
    endtask

    task automatic test_stretch_restart();
        int n, m, bad;
        bus.src_i[1] = 1'b0;
        n = 0;
        while (bus.rst_n_o !== 1'b0 && n < 40) begin tick(); n++; end
        repeat (5) tick();
        bus.src_i[1] = 1'b1;
        repeat (6) tick();
        // Debounced re-assertion lands exactly when the stretch counter reads 5.
        bus.src_i[1] = 1'b0;
        bad = 0;
        repeat (12) begin
            tick();
            if (bus.rst_n_o !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL restart_hold: rst_n high for %0d cycles, required 0", bad);
        end
        bus.cause_clr_i = 1'b1;
        tick();
        bus.cause_clr_i = 1'b0;
        tests++;
        if (bus.rst_cause_o !== 3'b010) begin
            fails++;
            $display("FAIL clear_race: got %b required 010", bus.rst_cause_o);
        end
        bus.src_i[1] = 1'b1;
        m = 0;
        while (bus.rst_n_o !== 1'b1 && m < 60) begin tick(); m++; end
        tests++;
        if (m != SS + DB + ST + 1) begin
            fails++;
            $display("FAIL restart_release: rst_n rose %0d cycles after release, required %0d", m, SS + DB + ST + 1);
        end
        bus.cause_clr_i = 1'b1;
        tick();
        bus.cause_clr_i = 1'b0;
    endtask

    task automatic test_mask_dominance();
        int n, bad;
        bus.src_en_i = 2'b10;
        bus.src_i    = 2'b11;
        bad = 0;
        repeat (20) begin
            tick();
            if (bus.rst_n_o !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0 || bus.rst_cause_o !== 3'b000) begin
            fails++;
            $display("FAIL mask: low cycles %0d cause %b required 0 and 000", bad, bus.rst_cause_o);
        end
        bus.src_i = 2'b01;
        n = 0;
        while (bus.rst_n_o !== 1'b0 && n < 40) begin tick(); n++; end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (bus.rst_n_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.rst_cause_o !== 3'b000) begin
            fails++;
            $display("FAIL dominance: rst_n=%b busy=%b cause=%b required 0 1 000",
                     bus.rst_n_o, bus.busy_o, bus.rst_cause_o);
        end
        repeat (SS + DB + 1) tick();
        tests++;
        if (bus.rst_cause_o !== 3'b010) begin
            fails++;
            $display("FAIL dominance_rehold: cause %b required 010", bus.rst_cause_o);
        end
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.rst_n_o !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL dominance_hold: rst_n high for %0d cycles, required 0", bad);
        end
        bus.src_i    = 2'b10;
        bus.src_en_i = 2'b11;
        bus.cause_clr_i = 1'b1;
        tick();
        bus.cause_clr_i = 1'b0;
        n = 0;
        while (bus.rst_n_o !== 1'b1 && n < 60) begin tick(); n++; end
        tests++;
        if (n >= 60) begin
            fails++;
            $display("FAIL dominance_exit: rst_n still low after %0d cycles", n);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(9) == 0) bus.src_i[$urandom_range(NS - 1)] ^= 1'b1;
            if ($urandom_range(99) == 0) bus.src_en_i = NS'($urandom_range(3));
            bus.sw_rst_req_i = ($urandom_range(59) == 0);
            bus.cause_clr_i  = ($urandom_range(19) == 0);
            rst              = ($urandom_range(499) == 0);
            tick();
            tests++;
            if (bus.rst_n_o !== m_rstn || bus.busy_o !== !m_rstn || bus.rst_cause_o !== m_cause) begin
                fails++;
                if (bad < 10)
                    $display("FAIL random_cycle%0d: rst_n=%b busy=%b cause=%b required rst_n=%b busy=%b cause=%b",
                             c, bus.rst_n_o, bus.busy_o, bus.rst_cause_o, m_rstn, !m_rstn, m_cause);
                bad++;
            end
        end
        rst = 1'b0;
        bus.sw_rst_req_i = 1'b0;
        bus.cause_clr_i  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_button();
        test_sw_reset();
        test_stretch_restart();
        test_mask_dominance();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
